multiplier_n: RTL and testbench

MULTIPLIER_N -- requirements
Module: multiplier_n

---
 rtl/multiplier_n_if.sv | 30 +++
 rtl/multiplier_n.sv | 137 +++++++++++++
 tb/tb_multiplier_n.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/multiplier_n_if.sv
// multiplier_n_if -- handshake/data bundle for the multiplier_n shift-add multiplier.
//   master : drives Load_Clear, Run, Signed_Mode, Data_In; observes results
//   slave  : the multiplier side; drives Aval/Bval/Xval/Busy/Done
//   Load_Clear  level, clear A/X and load B from Data_In
//   Run         level, rising edge starts a multiplication
//   Signed_Mode 1 = two's complement operands, 0 = unsigned
//   Data_In     multiplier on load, multiplicand on start
//   Aval/Bval   upper/lower product halves, Xval sign/carry above A
//   Busy/Done   run in progress / result ready
interface multiplier_n_if #(parameter int WIDTH = 8);
  logic             Load_Clear;
  logic             Run;
  logic             Signed_Mode;
  logic [WIDTH-1:0] Data_In;
  logic [WIDTH-1:0] Aval;
  logic [WIDTH-1:0] Bval;
  logic             Xval;
  logic             Busy;
  logic             Done;

  modport master (
    output Load_Clear, Run, Signed_Mode, Data_In,
    input  Aval, Bval, Xval, Busy, Done
  );

  modport slave (
    input  Load_Clear, Run, Signed_Mode, Data_In,
    output Aval, Bval, Xval, Busy, Done
  );
endinterface

// File: rtl/multiplier_n.sv
// multiplier_n -- sequential add/shift multiplier, WIDTH x WIDTH -> 2*WIDTH.
//   Clk      rising-edge clock
//   Reset_n  asynchronous active-low reset
//   bus      multiplier_n_if.slave (Load_Clear, Run, Signed_Mode, Data_In in;
//            Aval, Bval, Xval, Busy, Done out)
// One ADD + one SHIFT cycle per multiplier bit, so Busy lasts 2*WIDTH cycles.
// Product ends up in {A,B}; X holds the sign (signed) or 0 (unsigned).
// Signed mode subtracts S on the last bit, since the multiplier MSB carries
// weight -2^(WIDTH-1).
// Optional macro MULT_INPUT_SYNC_EN: two-flop synchronizers on every input
// (resetting to 0), adding two cycles of input latency.
module multiplier_n #(
  parameter int WIDTH = 8
) (
  input  logic          Clk,
  input  logic          Reset_n,
  multiplier_n_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a, b, s;
  logic             x, sgn, run_d, busy, done;
  logic [CW-1:0]    cnt;

  logic             run_i, lc_i, sm_i;
  logic [WIDTH-1:0] din_i;

`ifdef MULT_INPUT_SYNC_EN
  localparam int SW = WIDTH + 3;
  logic [SW-1:0] sync1, sync2;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {bus.Run, bus.Load_Clear, bus.Signed_Mode, bus.Data_In};
      sync2 <= sync1;
    end
  end

  assign {run_i, lc_i, sm_i, din_i} = sync2;
`else
  assign run_i = bus.Run;
  assign lc_i  = bus.Load_Clear;
  assign sm_i  = bus.Signed_Mode;
  assign din_i = bus.Data_In;
`endif

  logic           start, last;
  logic [WIDTH:0] a_ext, s_ext, sum;

  assign start = run_i & ~run_d;
  assign last  = (cnt == CW'(WIDTH - 1));

  // WIDTH+1 bits holds any sum of two WIDTH-bit operands, signed or not,
  // so the MSB is the true sign (signed) or carry (unsigned).
  always_comb begin
    a_ext = sgn ? {a[WIDTH-1], a} : {1'b0, a};
    s_ext = sgn ? {s[WIDTH-1], s} : {1'b0, s};
    sum   = (sgn && last) ? (a_ext - s_ext) : (a_ext + s_ext);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      s     <= '0;
      x     <= 1'b0;
      sgn   <= 1'b0;
      cnt   <= '0;
      run_d <= 1'b1;  // a Run held through reset release is not an edge
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      run_d <= run_i;
      case (state)
        IDLE: begin
          // Load_Clear wins; a simultaneous start is dropped since run_d
          // still follows Run.
          if (lc_i) begin
            a <= '0;
            x <= 1'b0;
            b <= din_i;
          end else if (start) begin
            s     <= din_i;
            sgn   <= sm_i;
            a     <= '0;
            x     <= 1'b0;
            cnt   <= '0;
            state <= ADD;
            busy  <= 1'b1;
          end
        end
        ADD: begin
          if (b[0]) {x, a} <= sum;
          state <= SHIFT;
        end
        SHIFT: begin
          a <= {x, a[WIDTH-1:1]};
          b <= {a[0], b[WIDTH-1:1]};
          if (!sgn) x <= 1'b0;
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= ADD;
          end
        end
        DONE: begin
          if (lc_i) begin
            a <= '0;
            x <= 1'b0;
            b <= din_i;
          end
          if (!run_i) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Aval = a;
  assign bus.Bval = b;
  assign bus.Xval = x;
  assign bus.Busy = busy;
  assign bus.Done = done;
endmodule

// File: tb/tb_multiplier_n.sv
// tb_multiplier_n -- directed checks of multiplier_n at WIDTH=8 and WIDTH=16.
module tb_multiplier_n;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 Clk = ~Clk;

  multiplier_n_if #(.WIDTH(8))  b8 ();
  multiplier_n_if #(.WIDTH(16)) b16 ();

  multiplier_n #(.WIDTH(8))  u8  (.Clk(Clk), .Reset_n(Reset_n), .bus(b8));
  multiplier_n #(.WIDTH(16)) u16 (.Clk(Clk), .Reset_n(Reset_n), .bus(b16));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load8(input logic [7:0] d);
    b8.Load_Clear = 1'b1;
    b8.Data_In    = d;
    @(negedge Clk);
    b8.Load_Clear = 1'b0;
  endtask

  // Start a run, optionally poke Load_Clear at busy cycle lc_at, wait for
  // Done, then check busy length, result, DONE hold with Run high, and exit.
  task automatic run8(input string tag, input logic sg, input logic [7:0] sv,
                      input int lc_at, input logic [7:0] ea, input logic [7:0] eb,
                      input logic ex);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    b8.Signed_Mode = sg;
    b8.Data_In     = sv;
    b8.Run         = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      b8.Load_Clear = 1'b0;
      if (b8.Busy) begin
        n++;
        if (n == 1) begin
          b8.Data_In     = 8'h5A;   // must not disturb the run
          b8.Signed_Mode = ~sg;
        end
        if (n == lc_at) b8.Load_Clear = 1'b1;
      end
      if (b8.Done) begin
        seen = 1;
        break;
      end
    end
    b8.Load_Clear = 1'b0;
    chk({tag, "_done"}, 32'(seen), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(n), 32'd16);
    chk({tag, "_A"}, 32'(b8.Aval), 32'(ea));
    chk({tag, "_B"}, 32'(b8.Bval), 32'(eb));
    chk({tag, "_X"}, 32'(b8.Xval), 32'(ex));
    repeat (3) @(negedge Clk);
    chk({tag, "_held_done"}, {30'd0, b8.Busy, b8.Done}, 32'd1);
    chk({tag, "_held_B"}, 32'(b8.Bval), 32'(eb));
    b8.Run = 1'b0;
    @(negedge Clk);
    chk({tag, "_idle"}, {30'd0, b8.Busy, b8.Done}, 32'd0);
  endtask

  initial begin
    int n;
    bit seen;
    b8.Load_Clear  = 1'b0; b8.Run  = 1'b1; b8.Signed_Mode  = 1'b0; b8.Data_In  = '0;
    b16.Load_Clear = 1'b0; b16.Run = 1'b0; b16.Signed_Mode = 1'b0; b16.Data_In = '0;

    // reset state, with Run held high through release
    repeat (2) @(negedge Clk);
    chk("rst_A", 32'(b8.Aval), 32'd0);
    chk("rst_B", 32'(b8.Bval), 32'd0);
    chk("rst_X", 32'(b8.Xval), 32'd0);
    chk("rst_busy_done", {30'd0, b8.Busy, b8.Done}, 32'd0);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    chk("held_run_no_start", {30'd0, b8.Busy, b8.Done}, 32'd0);
    b8.Run = 1'b0;
    @(negedge Clk);

    // 7 * -2 = -14, then chained -14 * 2 = -28
    load8(8'h07);
    chk("load_B", 32'(b8.Bval), 32'h07);
    chk("load_A", 32'(b8.Aval), 32'h00);
    run8("s7xm2", 1'b1, 8'hFE, 0, 8'hFF, 8'hF2, 1'b1);
    run8("chain", 1'b1, 8'h02, 0, 8'hFF, 8'hE4, 1'b1);

    // -128 * -128 = 16384 ; 255 * 255 = 65025
    load8(8'h80);
    run8("s80x80", 1'b1, 8'h80, 0, 8'h40, 8'h00, 1'b0);
    load8(8'hFF);
    run8("uFFxFF", 1'b0, 8'hFF, 0, 8'hFE, 8'h01, 1'b0);

    // Load_Clear at 5th busy cycle ignored
    load8(8'h07);
    run8("lc_mid", 1'b1, 8'hFE, 5, 8'hFF, 8'hF2, 1'b1);

    // Load_Clear in DONE clears A/X and loads B
    load8(8'h03);
    b8.Signed_Mode = 1'b1; b8.Data_In = 8'hFF; b8.Run = 1'b1;   // 3 * -1
    repeat (20) @(negedge Clk);
    chk("done_before_lc", 32'(b8.Done), 32'd1);
    b8.Load_Clear = 1'b1; b8.Data_In = 8'h2C;
    @(negedge Clk);
    b8.Load_Clear = 1'b0;
    chk("done_lc_A", {23'd0, b8.Xval, b8.Aval}, 32'h000);
    chk("done_lc_B", 32'(b8.Bval), 32'h2C);
    chk("done_lc_state", 32'(b8.Done), 32'd1);
    b8.Run = 1'b0;
    @(negedge Clk);

    // Load_Clear and start together: load wins, start dropped
    b8.Load_Clear = 1'b1; b8.Run = 1'b1; b8.Data_In = 8'h09;
    @(negedge Clk);
    b8.Load_Clear = 1'b0;
    chk("lc_start_B", 32'(b8.Bval), 32'h09);
    chk("lc_start_nobusy", 32'(b8.Busy), 32'd0);
    repeat (2) @(negedge Clk);
    chk("lc_start_still_idle", {30'd0, b8.Busy, b8.Done}, 32'd0);
    b8.Run = 1'b0;
    @(negedge Clk);

    // reset in the middle of a run
    load8(8'h05);
    b8.Signed_Mode = 1'b0; b8.Data_In = 8'h33; b8.Run = 1'b1;
    n = 0;
    for (int i = 0; i < 50 && n < 5; i++) begin
      @(negedge Clk);
      if (b8.Busy) n++;
    end
    chk("mid_rst_reached", 32'(n), 32'd5);
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_AB", {b8.Aval, b8.Bval}, 32'h0);
    chk("mid_rst_flags", {29'd0, b8.Xval, b8.Busy, b8.Done}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    chk("mid_rst_no_restart", {30'd0, b8.Busy, b8.Done}, 32'd0);
    b8.Run = 1'b0;
    @(negedge Clk);
    load8(8'h03);
    run8("after_rst", 1'b0, 8'h05, 0, 8'h00, 8'h0F, 1'b0);

    // WIDTH=16 unsigned: 0x10 * 0x1234 = 0x12340
    b16.Load_Clear = 1'b1; b16.Data_In = 16'h0010;
    @(negedge Clk);
    b16.Load_Clear = 1'b0;
    b16.Signed_Mode = 1'b0; b16.Data_In = 16'h1234; b16.Run = 1'b1;
    n = 0;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (b16.Busy) n++;
      if (b16.Done) begin
        seen = 1;
        break;
      end
    end
    chk("w16_done", 32'(seen), 32'd1);
    chk("w16_busy_cycles", 32'(n), 32'd32);
    chk("w16_A", 32'(b16.Aval), 32'h0001);
    chk("w16_B", 32'(b16.Bval), 32'h2340);
    chk("w16_X", 32'(b16.Xval), 32'd0);
    b16.Run = 1'b0;
    @(negedge Clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
